// File: rtl/wb_stream_reader_ctrl.sv
// Stream-to-memory writer: buffers a valid/ready word stream in a FWFT FIFO and
// writes it out as Wishbone linear incrementing bursts into a configured buffer.
module wb_stream_reader_ctrl #(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 4,
    parameter int MAX_BURST_LEN = 2**FIFO_AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WB_DW-1:0]     stream_s_data_i,
    input  logic                 stream_s_valid_i,
    output logic                 stream_s_ready_o,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    input  logic                 wbm_rty_i,
    input  logic                 enable,
    input  logic [WB_AW-1:0]     start_adr,
    input  logic [WB_AW-1:0]     buf_size,
    input  logic [WB_AW-1:0]     burst_size,
    output logic                 busy,
    output logic [WB_DW-1:0]     tx_cnt,
    output logic                 done,
    output logic                 err
);

    localparam int DEPTH = 2**FIFO_AW;
    localparam int BYTES = WB_DW/8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST
    } state_t;

    state_t state, state_nxt;

    // FIFO storage and bookkeeping
    logic [WB_DW-1:0]   fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   fifo_cnt;
    logic               fifo_full;
    logic               ready_en;
    logic               push, pop;

    // Latched configuration and transfer progress
    logic [WB_AW-1:0]   start_q, buf_q, burst_q, tx_q, beats_left;
    logic               busy_q, done_q, err_q;

    // FSM strobes
    logic               start, ld_burst, beat_ack, set_done, go_idle, bus_err;
    logic               beat_ok;

    logic [WB_AW-1:0]   remaining, req_len, burst_len;

    logic               unused_in;
    assign unused_in = ^wbm_dat_i;

    // ---------------------------------------------------------------- FIFO
    assign fifo_full        = (fifo_cnt == (FIFO_AW+1)'(DEPTH));
    assign stream_s_ready_o = ready_en & ~fifo_full;
    assign push             = stream_s_valid_i & stream_s_ready_o;
    assign pop              = beat_ack;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= stream_s_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------- burst length
    always_comb begin
        remaining = buf_q - tx_q;
        req_len   = (burst_q == '0) ? WB_AW'(1) : burst_q;
        burst_len = req_len;
        if (remaining < burst_len) begin
            burst_len = remaining;
        end
        if (WB_AW'(MAX_BURST_LEN) < burst_len) begin
            burst_len = WB_AW'(MAX_BURST_LEN);
        end
    end

    // A retry is simply a cycle without acknowledge: the beat stays on the bus.
    assign beat_ok = wbm_ack_i & ~wbm_rty_i;

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        ld_burst  = 1'b0;
        beat_ack  = 1'b0;
        set_done  = 1'b0;
        go_idle   = 1'b0;
        bus_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    start     = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    go_idle   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (remaining == '0) begin
                    set_done  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (WB_AW'(fifo_cnt) >= burst_len) begin
                    ld_burst  = 1'b1;
                    state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (wbm_err_i) begin
                    bus_err   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (beat_ok) begin
                    beat_ack = 1'b1;
                    if (beats_left == WB_AW'(1)) begin
                        if (tx_q + WB_AW'(1) == buf_q) begin
                            set_done  = 1'b1;
                            state_nxt = S_IDLE;
                        end else begin
                            state_nxt = S_WAIT;
                        end
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ----------------------------------------------- config and progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= '0;
            buf_q      <= '0;
            burst_q    <= '0;
            tx_q       <= '0;
            beats_left <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= set_done;
            if (start) begin
                start_q <= start_adr;
                buf_q   <= buf_size;
                burst_q <= burst_size;
                tx_q    <= '0;
                err_q   <= 1'b0;
                busy_q  <= 1'b1;
            end
            if (ld_burst) begin
                beats_left <= burst_len;
            end
            if (beat_ack) begin
                tx_q       <= tx_q + WB_AW'(1);
                beats_left <= beats_left - WB_AW'(1);
            end
            if (bus_err) begin
                err_q  <= 1'b1;
                busy_q <= 1'b0;
            end
            if (set_done || go_idle) begin
                busy_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------- outputs
    assign wbm_cyc_o = (state == S_BURST);
    assign wbm_stb_o = (state == S_BURST);
    assign wbm_we_o  = (state == S_BURST);
    assign wbm_sel_o = (state == S_BURST) ? '1 : '0;
    assign wbm_bte_o = 2'b00;
    assign wbm_cti_o = (state != S_BURST)             ? 3'b000 :
                       (beats_left == WB_AW'(1))      ? 3'b111 : 3'b010;
    // Address is derived from the word count so it wraps modulo 2**WB_AW.
    assign wbm_adr_o = start_q + tx_q * WB_AW'(BYTES);
    assign wbm_dat_o = fifo_mem[rd_ptr];

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign tx_cnt = WB_DW'(tx_q);

endmodule

// File: doc/wb_stream_reader_ctrl.md
Name: wb_stream_reader_ctrl

Overview:
- Ingests a valid/ready word stream into an internal FIFO and writes it to memory with Wishbone incrementing-burst writes.
- Fills a buffer of buf_size words starting at start_adr, then signals done.
- Performs the inverse of the memory-to-stream writer and sits upstream of memory on the same Wishbone fabric.
- Configuration comes from a register block that drives enable, start_adr, buf_size and burst_size.

Parameters:
- WB_AW, 32, Wishbone address width (byte addresses).
- WB_DW, 32, Wishbone and stream data width; must be a multiple of 8.
- FIFO_AW, 4, FIFO depth is 2**FIFO_AW words.
- MAX_BURST_LEN, 2**FIFO_AW, hard upper bound on beats per burst; must be <= 2**FIFO_AW.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- stream_s_data_i  in  WB_DW  stream data.
- stream_s_valid_i  in  1  stream data valid.
- stream_s_ready_o  out  1  high when the FIFO can accept a word.
- wbm_adr_o  out  WB_AW  write byte address.
- wbm_dat_o  out  WB_DW  write data (FIFO head).
- wbm_sel_o  out  WB_DW/8  byte selects.
- wbm_we_o  out  1  write enable.
- wbm_cyc_o  out  1  cycle.
- wbm_stb_o  out  1  strobe.
- wbm_cti_o  out  3  cycle type identifier.
- wbm_bte_o  out  2  burst type extension.
- wbm_dat_i  in  WB_DW  unused.
- wbm_ack_i  in  1  ack.
- wbm_err_i  in  1  bus error.
- wbm_rty_i  in  1  retry.
- enable  in  1  start and keep-running request.
- start_adr  in  WB_AW  buffer base byte address.
- buf_size  in  WB_AW  buffer length in words.
- burst_size  in  WB_AW  requested burst length in words.
- busy  out  1  transfer in progress.
- tx_cnt  out  WB_DW  words written in the current transfer.
- done  out  1  one-cycle pulse on completion.
- err  out  1  sticky bus-error flag.

Behaviour:
- Reset (rst_n low, asynchronous), values hold until the first clk edge after release:
  - FIFO empty; state IDLE.
  - busy, done, err, wbm_cyc_o, wbm_stb_o, wbm_we_o = 0.
  - tx_cnt = 0; wbm_adr_o = 0; wbm_cti_o = 0; wbm_bte_o = 0; wbm_sel_o = 0.
  - stream_s_ready_o = 0 while in reset, then 1 once the FIFO is empty.
- FIFO:
  - First-word-fall-through; stream_s_ready_o = !full; push on valid & ready.
  - Pop on wbm_ack_i during BURST.
  - Simultaneous push and pop leaves the count unchanged.
  - The FIFO is never flushed except by reset; stream words beyond buf_size stay queued for the next transfer.
  - The stream is accepted in every state, including IDLE.
- State IDLE:
  - On enable=1: latch start_adr and buf_size, clear tx_cnt and err, set busy=1, go to WAIT.
  - If the latched buf_size = 0: pulse done next cycle, clear busy, return to IDLE.
- State WAIT:
  - Compute L = min(max(burst_size,1), buf_size - tx_cnt, MAX_BURST_LEN).
  - When fifo_cnt >= L, go to BURST with a beat counter loaded with L.
  - If enable=0 in WAIT: return to IDLE, clear busy, no done pulse.
- State BURST:
  - Drive cyc = stb = we = 1, sel = all ones, bte = 2'b00 (linear).
  - wbm_adr_o = start_adr + tx_cnt * (WB_DW/8), computed modulo 2**WB_AW (wraps silently).
  - wbm_cti_o = 3'b010 on every beat except the last; last beat (and L = 1) uses 3'b111.
  - wbm_dat_o = FIFO head.
  - On each ack: pop, tx_cnt+1, address advances next cycle, beat counter-1.
  - Outputs hold stable until ack.
  - wbm_rty_i is treated as no ack (the beat is reissued unchanged).
  - After the last ack: drop cyc/stb the next cycle.
    - If tx_cnt = buf_size: pulse done for 1 cycle, clear busy, go to IDLE.
    - Otherwise go to WAIT.
  - enable falling mid-burst does not truncate the burst; the block then returns to IDLE without done.
- Error: wbm_err_i during BURST drops cyc/stb the next cycle, sets err=1 (held until the next start), clears busy and goes to IDLE; the FIFO head is not popped.
- A new enable while busy has no effect; config inputs are sampled only at start.

Test Plan:
- buf_size=8, burst_size=4, start_adr=0x1000, 8 stream words 1..8, ack every cycle -> two bursts at 0x1000 and 0x1010, cti 010,010,010,111 each, data 1..8, tx_cnt=8, one done pulse, busy low.
- buf_size=5, burst_size=4 -> bursts of 4 then 1; the second burst is a single beat with cti=111 at adr 0x1010.
- FIFO_AW=2, stream valid continuously, no ack for 10 cycles -> ready drops after 4 words; no word is lost or duplicated when acks resume.
- wbm_err_i on beat 2 of the first burst -> cyc low next cycle, err=1, busy=0, no done, tx_cnt=1; the next enable clears err.
- rty asserted for 3 cycles on beat 1 -> address and data held, tx_cnt unchanged until ack.
- Async rst_n pulse mid-burst -> cyc, stb, busy, done and tx_cnt read 0 immediately; the FIFO is empty after release.
